// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART command arbiter: idle byte, output FSM states
// and the arbitration policy selectors.
package uart_arb_pkg;

  localparam int unsigned IDLE_BYTE = 0;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/uart_arb_fifo.sv
// Command byte queue for the UART arbiter. Power-of-two depth; pointers wrap
// naturally and full/empty are decoded from the occupancy count.
module uart_arb_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              do_push, do_pop;

  assign full    = (level_q == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries data only, so it is left out of the reset domain.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_cmd_arbiter.sv
// Arbitrates command bytes from several sources into a FIFO feeding a UART.
// Optional UART_ARB_STATS_EN adds a saturating tx_count of loaded command bytes.
module uart_cmd_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_MODE   = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_SRC*DATA_W-1:0]   src_bits,
  input  logic [NUM_SRC-1:0]          src_valid,
  output logic [NUM_SRC-1:0]          src_ready,
  input  logic [NUM_SRC-1:0]          src_en,
  output logic [DATA_W-1:0]           tx_bits,
  input  logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef UART_ARB_STATS_EN
  ,
  output logic [15:0]                 tx_count
`endif
);

  localparam int PW = $clog2(NUM_SRC);

  logic [PW-1:0]     last_q, last_d;
  logic [NUM_SRC-1:0] eligible;
  logic [PW-1:0]     grant_idx;
  logic              grant_vld;
  int                idx;

  logic              fifo_full, fifo_empty, push, pop;
  logic [DATA_W-1:0] push_data, fifo_head;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_bits_q, tx_bits_d;

  assign eligible = src_valid & src_en;

  // Scan order starts at 0 for fixed priority, or just past the last grant for round robin.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (ARB_MODE == ARB_RR) idx = (int'(last_q) + 1 + k) % NUM_SRC;
      else                    idx = k;
      if (!grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    src_ready = '0;
    if (reset && grant_vld && !fifo_full) src_ready[grant_idx] = 1'b1;
  end

  assign push      = |src_ready;
  assign push_data = src_bits[int'(grant_idx)*DATA_W +: DATA_W];
  assign last_d    = push ? grant_idx : last_q;

  uart_arb_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (push_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // tx_bits only moves on a tx_done edge so each byte spans one whole frame.
  always_comb begin
    state_d   = state_q;
    tx_bits_d = tx_bits_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_done && !fifo_empty) begin
          tx_bits_d = fifo_head;
          pop       = 1'b1;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (tx_done) begin
          if (!fifo_empty) begin
            tx_bits_d = fifo_head;
            pop       = 1'b1;
          end else begin
            tx_bits_d = DATA_W'(IDLE_BYTE);
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      tx_bits_q <= DATA_W'(IDLE_BYTE);
      last_q    <= PW'(NUM_SRC - 1);
    end else begin
      state_q   <= state_d;
      tx_bits_q <= tx_bits_d;
      last_q    <= last_d;
    end
  end

  assign tx_bits = tx_bits_q;

`ifdef UART_ARB_STATS_EN
  logic [15:0] tx_count_q, tx_count_d;

  always_comb begin
    tx_count_d = tx_count_q;
    if (pop && tx_count_q != 16'hFFFF) tx_count_d = tx_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tx_count_q <= '0;
    else        tx_count_q <= tx_count_d;
  end

  assign tx_count = tx_count_q;
`endif

endmodule

// File: tb/tb_uart_cmd_arbiter.sv
// Bench for uart_cmd_arbiter: a fixed-priority and a round-robin instance share
// stimulus and are checked every cycle against a queue-based model.
module tb_uart_cmd_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N*W-1:0] src_bits = '0;
  logic [N-1:0]   src_valid = '0;
  logic [N-1:0]   src_en = '1;
  logic           tx_done = 1'b0;

  logic [N-1:0]   rdy [2];
  logic [W-1:0]   txb [2];
  logic [LW-1:0]  lvl [2];
`ifdef UART_ARB_STATS_EN
  logic [15:0]    cnt [2];
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0]   mq [2][$];
  logic [W-1:0]   mtx [2];
  int             mlast [2];
  int             mcnt [2];

  always #5 clock = ~clock;

  uart_cmd_arbiter #(.NUM_SRC(N), .DATA_W(W), .FIFO_DEPTH(D), .ARB_MODE(0)) dut_fp (
    .clock(clock), .reset(reset), .src_bits(src_bits), .src_valid(src_valid),
    .src_ready(rdy[0]), .src_en(src_en), .tx_bits(txb[0]), .tx_done(tx_done),
    .fifo_level(lvl[0])
`ifdef UART_ARB_STATS_EN
    , .tx_count(cnt[0])
`endif
  );

  uart_cmd_arbiter #(.NUM_SRC(N), .DATA_W(W), .FIFO_DEPTH(D), .ARB_MODE(1)) dut_rr (
    .clock(clock), .reset(reset), .src_bits(src_bits), .src_valid(src_valid),
    .src_ready(rdy[1]), .src_en(src_en), .tx_bits(txb[1]), .tx_done(tx_done),
    .fifo_level(lvl[1])
`ifdef UART_ARB_STATS_EN
    , .tx_count(cnt[1])
`endif
  );

  task automatic chk(input string name, input int m, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t: got %0h, expected %0h", name, m, $time, act, exp);
    end
  endtask

  // Which source should win: lowest eligible index, or first eligible after the last winner.
  function automatic int pick(input int mode, input int last, input logic [N-1:0] elig);
    int winner = -1;
    for (int k = 0; k < N; k++) begin
      int i = (mode == 1) ? (last + 1 + k) % N : k;
      if (winner < 0 && elig[i]) winner = i;
    end
    return winner;
  endfunction

  function automatic logic [N-1:0] exp_ready(input int m);
    int g;
    if (!reset || mq[m].size() >= D) return '0;
    g = pick(m, mlast[m], src_valid & src_en);
    if (g < 0) return '0;
    return N'(1) << g;
  endfunction

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mtx[m]   = '0;
      mlast[m] = N - 1;
      mcnt[m]  = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_clear();
      else begin
        for (int m = 0; m < 2; m++) begin
          logic [N-1:0] r;
          int g;
          r = exp_ready(m);
          g = pick(m, mlast[m], src_valid & src_en);
          if (tx_done) begin
            if (mq[m].size() > 0) begin
              mtx[m] = mq[m].pop_front();
              if (mcnt[m] < 16'hFFFF) mcnt[m]++;
            end else begin
              mtx[m] = '0;
            end
          end
          if (r != '0) begin
            mq[m].push_back(src_bits[g*W +: W]);
            mlast[m] = g;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      for (int m = 0; m < 2; m++) begin
        chk("src_ready", m, 32'(rdy[m]), 32'(exp_ready(m)));
        chk("tx_bits", m, 32'(txb[m]), 32'(mtx[m]));
        chk("fifo_level", m, 32'(lvl[m]), 32'(mq[m].size()));
`ifdef UART_ARB_STATS_EN
        chk("tx_count", m, 32'(cnt[m]), 32'(mcnt[m]));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  logic [N-1:0] ord [6];
  int acc;

  initial begin
    // Reset state, with every source offering so that ready gating is visible.
    src_valid = '1;
    repeat (2) tick();
    chk("rst_ready", 0, 32'(rdy[0]), 32'h0);
    chk("rst_ready", 1, 32'(rdy[1]), 32'h0);
    chk("rst_tx", 0, 32'(txb[0]), 32'h0);
    chk("rst_level", 0, 32'(lvl[0]), 32'h0);
    src_valid = '0;
    reset = 1'b1;
    tick();

    // Two sources contend: 0x12 first, then 0x34.
    src_bits  = {8'h00, 8'h34, 8'h12};
    src_valid = 3'b011;
    #3 chk("fp_first_grant", 0, 32'(rdy[0]), 32'h1);
    tick();
    src_valid = 3'b010;
    tick();
    src_valid = 3'b000;
    chk("two_queued", 0, 32'(lvl[0]), 32'h2);
    pulse_done();
    chk("tx_first", 0, 32'(txb[0]), 32'h12);
    pulse_done();
    chk("tx_second", 0, 32'(txb[0]), 32'h34);
    pulse_done();
    chk("tx_idle", 0, 32'(txb[0]), 32'h00);

    // Round robin with all three continuously valid while the UART drains.
    reset_pulse();
    src_bits  = {8'hC3, 8'hB2, 8'hA1};
    src_valid = 3'b111;
    tx_done   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3 ord[i] = rdy[1];
      chk("fp_always_src0", 0, 32'(rdy[0]), 32'h1);
      tick();
    end
    tx_done   = 1'b0;
    src_valid = 3'b000;
    chk("rr_g0", 1, 32'(ord[0]), 32'h1);
    chk("rr_g1", 1, 32'(ord[1]), 32'h2);
    chk("rr_g2", 1, 32'(ord[2]), 32'h4);
    chk("rr_g3", 1, 32'(ord[3]), 32'h1);
    chk("rr_g4", 1, 32'(ord[4]), 32'h2);
    chk("rr_g5", 1, 32'(ord[5]), 32'h4);
    chk("rr_tx_last", 1, 32'(txb[1]), 32'hB2);
`ifdef UART_ARB_STATS_EN
    chk("count_five", 1, 32'(cnt[1]), 32'd5);
`endif

    // Fill to full with no tx_done, then free exactly one slot.
    reset_pulse();
    src_valid = 3'b001;
    for (int i = 0; i < 6; i++) begin
      src_bits[7:0] = 8'h40 + 8'(i);
      tick();
    end
    chk("full_level", 0, 32'(lvl[0]), 32'h4);
    chk("full_ready", 0, 32'(rdy[0]), 32'h0);
    pulse_done();
    chk("full_tx", 0, 32'(txb[0]), 32'h40);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      #3 if (rdy[0] != '0) acc++;
      tick();
    end
    src_valid = 3'b000;
    chk("one_more_accept", 0, acc, 32'd1);
    chk("refull_level", 0, 32'(lvl[0]), 32'h4);

    // Disabled source is never granted; clearing enables keeps queued bytes.
    reset_pulse();
    src_bits  = {8'h55, 8'h00, 8'h00};
    src_valid = 3'b100;
    src_en    = 3'b011;
    #3 chk("disabled_ready", 0, 32'(rdy[0]), 32'h0);
    tick();
    src_en = 3'b111;
    tick();
    src_valid = 3'b000;
    src_en    = 3'b000;
    chk("kept_level", 0, 32'(lvl[0]), 32'h1);
    pulse_done();
    chk("single_tx", 0, 32'(txb[0]), 32'h55);
    repeat (5) tick();
    chk("single_hold", 1, 32'(txb[1]), 32'h55);
    pulse_done();
    chk("single_idle", 0, 32'(txb[0]), 32'h00);
    src_en = 3'b111;

    // Reset asserted between edges while busy with three bytes behind.
    reset_pulse();
    src_valid = 3'b001;
    for (int i = 0; i < 4; i++) begin
      src_bits[7:0] = 8'h61 + 8'(i);
      tick();
    end
    src_valid = 3'b000;
    pulse_done();
    chk("busy_level", 0, 32'(lvl[0]), 32'h3);
    chk("busy_tx", 0, 32'(txb[0]), 32'h61);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("async_tx", 0, 32'(txb[0]), 32'h0);
    chk("async_level", 0, 32'(lvl[0]), 32'h0);
    chk("async_tx", 1, 32'(txb[1]), 32'h0);
    chk("async_level", 1, 32'(lvl[1]), 32'h0);
    tick();
    reset = 1'b1;
    tick();
    pulse_done();
    chk("empty_done_ignored", 0, 32'(txb[0]), 32'h0);
    src_bits[7:0] = 8'h77;
    src_valid     = 3'b001;
    tick();
    src_valid = 3'b000;
    pulse_done();
    chk("resume_tx", 0, 32'(txb[0]), 32'h77);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
